// File: rtl/cpu_pkg.sv
// Shared CPU definitions: RAM geometry, byte order, store request format and
// process-block offsets used by task-switch register saves.
package cpu_pkg;

    localparam int RAM_ADDR_W = 10;

    // Big-endian byte order: data[31:24] is byte 0 and lands at the lowest address.
    localparam int BYTE0_HI = 31;

    localparam int ADDRESS_PC    = 0;
    localparam int ADDRESS_REG   = 4;
    localparam int ADDRESS_FLAGS = 36;
    localparam int ADDRESS_SP    = 40;

    typedef struct packed {
        logic [RAM_ADDR_W-1:0] addr;
        logic [31:0]           data;
        logic [2:0]            len;
    } store_req_t;

    typedef enum logic {
        ST_IDLE,
        ST_WRITE
    } store_state_e;

    function automatic logic len_legal(input logic [2:0] len);
        return (len >= 3'd1) && (len <= 3'd4);
    endfunction

endpackage

// File: rtl/ram_store_unit_if.sv
// Store request valid/ready bus between the decoder/execute side and the store unit.
interface ram_store_unit_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic [2:0]        req_len;

    modport master (output req_valid, req_addr, req_data, req_len, input  req_ready);
    modport slave  (input  req_valid, req_addr, req_data, req_len, output req_ready);
endinterface

// File: rtl/store_req_fifo.sv
// Synchronous request FIFO with occupancy count; read data is the current head.
module store_req_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clka,
    input  logic                     rst,
    input  logic                     push_i,
    input  store_req_t               wdata_i,
    input  logic                     pop_i,
    output store_req_t               rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    store_req_t      mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    // Pointers are log2(DEPTH) wide so they wrap without explicit compare.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clka) begin
        if (push_i) mem[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/ram_store_unit.sv
// Port-A write engine: queues 1..4 byte store requests and writes one byte per clka.
module ram_store_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic              clka,
    input  logic              rst,
    ram_store_unit_if.slave   req,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [7:0]        dia,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CW = $clog2(DEPTH) + 1;

    store_state_e      state_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [31:0]       cur_data_q;
    logic [2:0]        rem_q;
    logic              ena_q, wea_q, done_q, err_q, busy_q;
    logic [ADDR_W-1:0] addra_q;
    logic [7:0]        dia_q;

    store_req_t      wr_req, head;
    logic [CW-1:0]   count;
    logic            full, empty;
    logic            accept, push, pop, last_byte, write_d;
    logic [CW-1:0]   count_d;

    assign req.req_ready = !full;
    assign accept        = req.req_valid && !full;
    assign push          = accept && len_legal(req.req_len);
    assign last_byte     = (state_q == ST_WRITE) && (rem_q == 3'd1);
    assign pop           = !empty && ((state_q == ST_IDLE) || last_byte);

    always_comb begin
        wr_req      = '0;
        wr_req.addr = RAM_ADDR_W'(req.req_addr);
        wr_req.data = req.req_data;
        wr_req.len  = req.req_len;
    end

    store_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clka    (clka),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (wr_req),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // busy is registered from next-cycle occupancy and next engine state.
    always_comb begin
        count_d = count + CW'(push) - CW'(pop);
        write_d = (state_q == ST_IDLE) ? !empty : !(last_byte && empty);
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= '0;
            cur_data_q <= '0;
            rem_q      <= '0;
            ena_q      <= 1'b0;
            wea_q      <= 1'b0;
            addra_q    <= '0;
            dia_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            err_q  <= accept && !len_legal(req.req_len);
            busy_q <= (count_d != '0) || write_d;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ena_q <= 1'b0;
                    wea_q <= 1'b0;
                    if (!empty) state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    ena_q      <= 1'b1;
                    wea_q      <= 1'b1;
                    addra_q    <= cur_addr_q;
                    dia_q      <= cur_data_q[BYTE0_HI -: 8];
                    cur_data_q <= {cur_data_q[23:0], 8'h00};
                    cur_addr_q <= cur_addr_q + ADDR_W'(1);
                    rem_q      <= rem_q - 3'd1;
                    if (rem_q == 3'd1) begin
                        done_q <= 1'b1;
                        if (empty) state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // A pop overrides the shift/increment above so the next request starts seamlessly.
            if (pop) begin
                cur_addr_q <= ADDR_W'(head.addr);
                cur_data_q <= head.data;
                rem_q      <= head.len;
            end
        end
    end

    assign ena   = ena_q;
    assign wea   = wea_q;
    assign addra = addra_q;
    assign dia   = dia_q;
    assign done  = done_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_ram_store_unit.sv
// Directed self-checking bench for ram_store_unit; expected writes are hand-computed.
module tb_ram_store_unit;

    logic       clka = 1'b0;
    logic       rst;
    logic       ena, wea, busy, done, err;
    logic [9:0] addra;
    logic [7:0] dia;

    int checks = 0;
    int errors = 0;

    ram_store_unit_if #(.ADDR_W(10)) rif ();

    ram_store_unit #(.ADDR_W(10), .DEPTH(2)) dut (
        .clka  (clka),
        .rst   (rst),
        .req   (rif),
        .ena   (ena),
        .wea   (wea),
        .addra (addra),
        .dia   (dia),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clka = ~clka;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        @(negedge clka);
    endtask

    task automatic drive(input logic v, input logic [9:0] a, input logic [31:0] d, input logic [2:0] l);
        rif.req_valid = v;
        rif.req_addr  = a;
        rif.req_data  = d;
        rif.req_len   = l;
    endtask

    task automatic chk_wr(input string tag, input logic [9:0] a, input logic [7:0] d, input logic dn);
        chk({tag, ".ena"},   32'(ena),   32'd1);
        chk({tag, ".wea"},   32'(wea),   32'd1);
        chk({tag, ".addra"}, 32'(addra), 32'(a));
        chk({tag, ".dia"},   32'(dia),   32'(d));
        chk({tag, ".done"},  32'(done),  32'(dn));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ena"},  32'(ena),  32'd0);
        chk({tag, ".wea"},  32'(wea),  32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
    endtask

    initial begin
        drive(1'b0, '0, '0, '0);
        rst = 1'b0;

        // Reset asserted mid-cycle
        #3 rst = 1'b1;
        #1;
        chk("rst.ena",   32'(ena),   32'd0);
        chk("rst.wea",   32'(wea),   32'd0);
        chk("rst.addra", 32'(addra), 32'd0);
        chk("rst.dia",   32'(dia),   32'd0);
        chk("rst.done",  32'(done),  32'd0);
        chk("rst.err",   32'(err),   32'd0);
        chk("rst.busy",  32'(busy),  32'd0);
        chk("rst.ready", 32'(rif.req_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();

        // Single 4-byte store
        drive(1'b1, 10'h050, 32'hDEADBEEF, 3'd4);
        tick();
        drive(1'b0, '0, '0, '0);
        chk("s4.busy", 32'(busy), 32'd1);
        chk_idle("s4.acc");
        tick();
        chk_idle("s4.load");
        tick(); chk_wr("s4.b0", 10'h050, 8'hDE, 1'b0);
        tick(); chk_wr("s4.b1", 10'h051, 8'hAD, 1'b0);
        tick(); chk_wr("s4.b2", 10'h052, 8'hBE, 1'b0);
        tick(); chk_wr("s4.b3", 10'h053, 8'hEF, 1'b1);
        tick();
        chk_idle("s4.end");
        chk("s4.hold_addra", 32'(addra), 32'h053);
        chk("s4.hold_dia",   32'(dia),   32'hEF);
        chk("s4.busy_end",   32'(busy),  32'd0);

        // Back-to-back requests with no gap
        drive(1'b1, 10'h010, 32'hAA000000, 3'd1);
        tick();
        drive(1'b1, 10'h020, 32'h1234ABCD, 3'd2);
        tick();
        drive(1'b0, '0, '0, '0);
        chk("bb.ready", 32'(rif.req_ready), 32'd1);
        tick(); chk_wr("bb.w0", 10'h010, 8'hAA, 1'b1);
        tick(); chk_wr("bb.w1", 10'h020, 8'h12, 1'b0);
        tick(); chk_wr("bb.w2", 10'h021, 8'h34, 1'b1);
        tick(); chk_idle("bb.end");

        // FIFO fills while a long request drains
        drive(1'b1, 10'h200, 32'h11223344, 3'd4);
        tick();
        drive(1'b1, 10'h300, 32'h99000000, 3'd1);
        tick();
        chk("full.ready1", 32'(rif.req_ready), 32'd1);
        drive(1'b1, 10'h301, 32'h88000000, 3'd1);
        tick();
        drive(1'b0, '0, '0, '0);
        chk("full.ready2", 32'(rif.req_ready), 32'd0);
        chk_wr("full.a0", 10'h200, 8'h11, 1'b0);
        tick(); chk("full.ready3", 32'(rif.req_ready), 32'd0);
        tick(); chk("full.ready4", 32'(rif.req_ready), 32'd0);
        tick();
        chk_wr("full.a3", 10'h203, 8'h44, 1'b1);
        chk("full.ready5", 32'(rif.req_ready), 32'd1);
        tick(); chk_wr("full.b", 10'h300, 8'h99, 1'b1);
        tick(); chk_wr("full.c", 10'h301, 8'h88, 1'b1);
        tick(); chk_idle("full.end");

        // Address wrap-around
        drive(1'b1, 10'h3FF, 32'h55660000, 3'd2);
        tick();
        drive(1'b0, '0, '0, '0);
        tick();
        tick(); chk_wr("wrap.b0", 10'h3FF, 8'h55, 1'b0);
        tick(); chk_wr("wrap.b1", 10'h000, 8'h66, 1'b1);
        tick(); chk_idle("wrap.end");

        // Illegal lengths: 0 and 5
        drive(1'b1, 10'h0AA, 32'hFFFFFFFF, 3'd0);
        tick();
        drive(1'b0, '0, '0, '0);
        chk("bad0.err",   32'(err),  32'd1);
        chk("bad0.busy",  32'(busy), 32'd0);
        chk("bad0.ready", 32'(rif.req_ready), 32'd1);
        tick();
        chk("bad0.err_clr", 32'(err), 32'd0);
        chk_idle("bad0.q");
        drive(1'b1, 10'h0AB, 32'hFFFFFFFF, 3'd5);
        tick();
        drive(1'b0, '0, '0, '0);
        chk("bad5.err",  32'(err),  32'd1);
        chk("bad5.busy", 32'(busy), 32'd0);
        tick();
        chk("bad5.err_clr", 32'(err), 32'd0);
        chk_idle("bad5.q1");
        tick();
        chk_idle("bad5.q2");
        chk("bad5.busy2", 32'(busy), 32'd0);

        // Reset in the middle of a store with another request queued
        drive(1'b1, 10'h100, 32'hA1B2C3D4, 3'd4);
        tick();
        drive(1'b1, 10'h180, 32'h77880000, 3'd2);
        tick();
        drive(1'b0, '0, '0, '0);
        tick(); chk_wr("rmo.b0", 10'h100, 8'hA1, 1'b0);
        tick(); chk_wr("rmo.b1", 10'h101, 8'hB2, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_idle("rmo.rst");
        chk("rmo.busy",  32'(busy),  32'd0);
        chk("rmo.addra", 32'(addra), 32'd0);
        @(negedge clka);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_idle($sformatf("rmo.after%0d", i));
            chk($sformatf("rmo.busy%0d", i), 32'(busy), 32'd0);
        end
        chk("rmo.ready", 32'(rif.req_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
